sync_fifo_level: RTL

//   Single-clock FIFO: the same-clock counterpart of the async FIFO, used where producer and consumer share one clock.

---
 rtl/sync_fifo_level.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy output, registered almost-full/almost-empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module sync_fifo_level #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE_LOG2  = 5,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_write_en,
    input  logic [DATA_WIDTH-1:0] p_write_data,
    output logic                  p_write_full,
    output logic                  p_write_almost_full,
    input  logic                  p_read_en,
    output logic [DATA_WIDTH-1:0] p_read_data,
    output logic                  p_read_valid,
    output logic                  p_read_empty,
    output logic                  p_read_almost_empty,
    output logic [SIZE_LOG2:0]    p_level,
    output logic                  p_overflow,
    output logic                  p_underflow
);

    localparam int DEPTH = 2 ** SIZE_LOG2;
    localparam int PW    = SIZE_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_level: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_level: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [PW-1:0]         level_r;
    logic [PW-1:0]         level_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  af_r;
    logic                  ae_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Request acceptance and next occupancy; flags below are registered from level_next_s
    always_comb begin
        wr_acc_s     = p_write_en && !full_r;
        rd_acc_s     = p_read_en && !empty_r;
        level_next_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_next_s = level_r + PW'(1);
            2'b01:   level_next_s = level_r - PW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Storage array; not cleared by reset, writes suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_r[wptr_r[SIZE_LOG2-1:0]] <= p_write_data;
        end
    end

    // Pointers, level, threshold flags and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            level_r <= {PW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            if (wr_acc_s) wptr_r <= wptr_r + PW'(1);
            if (rd_acc_s) rptr_r <= rptr_r + PW'(1);
            level_r <= level_next_s;
            full_r  <= (level_next_s == DEPTH_L);
            empty_r <= (level_next_s == {PW{1'b0}});
            af_r    <= (level_next_s >= AF_L);
            ae_r    <= (level_next_s <= AE_L);
            if (p_write_en && full_r) ovf_r <= 1'b1;
            if (p_read_en && empty_r) unf_r <= 1'b1;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so reset presents zero data
        assign p_read_data  = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rptr_r[SIZE_LOG2-1:0]];
        assign p_read_valid = !empty_r;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_r;
        logic                  rvalid_r;

        // Registered read port: data one cycle after an accepted read, held otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_r  <= {DATA_WIDTH{1'b0}};
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rd_acc_s;
                if (rd_acc_s) rdata_r <= mem_r[rptr_r[SIZE_LOG2-1:0]];
            end
        end

        assign p_read_data  = rdata_r;
        assign p_read_valid = rvalid_r;
    end

    assign p_write_full        = full_r;
    assign p_write_almost_full = af_r;
    assign p_read_empty        = empty_r;
    assign p_read_almost_empty = ae_r;
    assign p_level             = level_r;
    assign p_overflow          = ovf_r;
    assign p_underflow         = unf_r;

endmodule
